// File: rtl/soc_msp430_ram_dma_pkg.sv
// Shared types and RAM signalling constants for the soc_msp430_ram_dma block-move engine.
package soc_msp430_ram_dma_pkg;

   typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

   // Native RAM macro signalling: chip enable and write enables are low active.
   localparam logic [1:0] RAM_WEN_WORD = 2'b00;
   localparam logic [1:0] RAM_WEN_READ = 2'b11;
   localparam logic       RAM_CEN_ON   = 1'b0;

endpackage

// File: rtl/soc_msp430_ram_dma.sv
// Block copy / fill engine driving one port of the dual-port RAM macro.
// Define SOC_MSP430_RAM_DMA_CHECKSUM_EN to add a 16-bit running checksum of written words.
module soc_msp430_ram_dma
   import soc_msp430_ram_dma_pkg::*;
#(
   parameter int ADDR_MSB = 6,
   parameter int MEM_SIZE = 256
) (
   input  logic                mclk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_fill,
   input  logic [ADDR_MSB:0]   cmd_src,
   input  logic [ADDR_MSB:0]   cmd_dst,
   input  logic [ADDR_MSB+1:0] cmd_len,
   input  logic [15:0]         cmd_data,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   output logic                done_abort,
   output logic [ADDR_MSB+1:0] xfer_cnt,
   output logic [ADDR_MSB:0]   ram_addr,
   output logic                ram_cen,
   output logic [1:0]          ram_wen,
   output logic [15:0]         ram_din,
   input  logic [15:0]         ram_dout
`ifdef SOC_MSP430_RAM_DMA_CHECKSUM_EN
   ,
   output logic [15:0]         checksum
`endif
);

   localparam int               CW        = ADDR_MSB + 2;
   localparam logic [CW-1:0]    MAX_WORDS = CW'(MEM_SIZE / 2);

   state_t              state;
   logic [ADDR_MSB:0]   src_ptr;
   logic [ADDR_MSB:0]   dst_ptr;
   logic [CW-1:0]       remaining;
   logic [CW-1:0]       len_clamped;
   logic                fill_mode;
   logic [15:0]         fill_data;

   // A length beyond the RAM size would only rewrite words already covered.
   assign len_clamped = (cmd_len > MAX_WORDS) ? MAX_WORDS : cmd_len;

   // RAM port is a pure decode of the registered state; copy data flows through from the previous read.
   always_comb begin
      // NOTE: every output gets a default first, so no path through the case can infer a latch.
      ram_cen  = ~RAM_CEN_ON;
      ram_wen  = RAM_WEN_READ;
      ram_addr = '0;
      ram_din  = '0;
      unique case (state)
         RD: begin
            ram_cen  = RAM_CEN_ON;
            ram_addr = src_ptr;
         end
         WR: begin
            ram_cen  = RAM_CEN_ON;
            ram_wen  = RAM_WEN_WORD;
            ram_addr = dst_ptr;
            ram_din  = fill_mode ? fill_data : ram_dout;
         end
         default: ;
      endcase
   end

   always_ff @(posedge mclk) begin
      // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state      <= IDLE;
         cmd_ready  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         done_abort <= 1'b0;
         xfer_cnt   <= '0;
         src_ptr    <= '0;
         dst_ptr    <= '0;
         remaining  <= '0;
         fill_mode  <= 1'b0;
         fill_data  <= '0;
`ifdef SOC_MSP430_RAM_DMA_CHECKSUM_EN
         checksum   <= '0;
`endif
      end else begin
         done       <= 1'b0;
         done_abort <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  src_ptr   <= cmd_src;
                  dst_ptr   <= cmd_dst;
                  remaining <= len_clamped;
                  fill_mode <= cmd_fill;
                  fill_data <= cmd_data;
                  xfer_cnt  <= '0;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
`ifdef SOC_MSP430_RAM_DMA_CHECKSUM_EN
                  checksum  <= '0;
`endif
                  if (len_clamped == '0) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end else begin
                     state <= cmd_fill ? WR : RD;
                  end
               end
            end
            RD: begin
               if (abort) begin
                  state      <= FIN;
                  done       <= 1'b1;
                  done_abort <= 1'b1;
               end else begin
                  state <= WR;
               end
            end
            WR: begin
               src_ptr   <= src_ptr + 1'b1;
               dst_ptr   <= dst_ptr + 1'b1;
               xfer_cnt  <= xfer_cnt + 1'b1;
               remaining <= remaining - 1'b1;
`ifdef SOC_MSP430_RAM_DMA_CHECKSUM_EN
               checksum  <= checksum + ram_din;
`endif
               // The write in this cycle always lands, even when it is also the aborted one.
               if (abort || remaining == CW'(1)) begin
                  state      <= FIN;
                  done       <= 1'b1;
                  done_abort <= abort;
               end else begin
                  state <= fill_mode ? WR : RD;
               end
            end
            FIN: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_soc_msp430_ram_dma.sv
// Self-checking bench for soc_msp430_ram_dma: directed table, hand sequences and random commands
// checked against a word-level model of copy/fill semantics over a behavioural RAM.
module tb_soc_msp430_ram_dma;

   localparam int WORDS = 128;

   typedef struct {
      bit          fill;
      int          src;
      int          dst;
      int          len;
      logic [15:0] data;
      int          akind;   // 0 none, 1 abort on n-th write, 2 abort on n-th read
      int          an;
   } cmd_t;

   typedef struct {
      cmd_t c;
      int   exp_lat;
      int   exp_cnt;
      bit   exp_ab;
   } vec_t;

   logic        mclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_fill = 1'b0;
   logic [6:0]  cmd_src = '0;
   logic [6:0]  cmd_dst = '0;
   logic [7:0]  cmd_len = '0;
   logic [15:0] cmd_data = '0;
   logic        abort = 1'b0;
   logic        cmd_ready, busy, done, done_abort;
   logic [7:0]  xfer_cnt;
   logic [6:0]  ram_addr;
   logic        ram_cen;
   logic [1:0]  ram_wen;
   logic [15:0] ram_din;
   logic [15:0] ram_dout;
`ifdef SOC_MSP430_RAM_DMA_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   soc_msp430_ram_dma dut (
`ifdef SOC_MSP430_RAM_DMA_CHECKSUM_EN
      .checksum(checksum),
`endif
      .mclk(mclk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_fill(cmd_fill), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
      .cmd_data(cmd_data), .abort(abort), .busy(busy), .done(done), .done_abort(done_abort),
      .xfer_cnt(xfer_cnt), .ram_addr(ram_addr), .ram_cen(ram_cen), .ram_wen(ram_wen),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   always #5 mclk = ~mclk;

   // Behavioural RAM port: read data appears the cycle after the access.
   logic [15:0] mem [WORDS];
   logic        preset_en = 1'b0;
   logic [6:0]  preset_addr = '0;
   logic [15:0] preset_data = '0;
   int          wr_count = 0;
   int          acc_count = 0;

   always @(posedge mclk) begin
      if (preset_en) begin
         mem[preset_addr] <= preset_data;
      end else if (ram_cen == 1'b0) begin
         acc_count <= acc_count + 1;
         if (ram_wen == 2'b00) begin
            mem[ram_addr] <= ram_din;
            wr_count      <= wr_count + 1;
         end
         ram_dout <= mem[ram_addr];
      end
   end

   // Reference state
   logic [15:0] exp_mem [WORDS];
   logic [15:0] exp_sum;
   int          total = 0;
   int          bad = 0;
   int          wr0, acc0, exp_w, exp_r;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   task automatic preset(int a, logic [15:0] d);
      preset_en   = 1'b1;
      preset_addr = 7'(a);
      preset_data = d;
      step();
      preset_en   = 1'b0;
      exp_mem[a]  = d;
   endtask

   task automatic rand_mem();
      for (int i = 0; i < WORDS; i++) preset(i, 16'($urandom));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   function automatic cmd_t mk(bit f, int s, int d, int l, logic [15:0] v, int k, int n);
      cmd_t c;
      c.fill = f; c.src = s; c.dst = d; c.len = l; c.data = v; c.akind = k; c.an = n;
      return c;
   endfunction

   function automatic int writes_of(cmd_t c);
      if (c.akind == 1) return (c.an < c.len) ? c.an : c.len;
      if (c.akind == 2) return c.an - 1;
      return c.len;
   endfunction

   function automatic int reads_of(cmd_t c);
      if (c.fill) return 0;
      if (c.akind == 2) return c.an;
      return writes_of(c);
   endfunction

   // Accept cycle is cycle 0; copy costs two cycles per word, fill one, then one cycle to done.
   function automatic int lat_of(cmd_t c);
      if (c.akind == 2) return 2 * c.an;
      return c.fill ? writes_of(c) + 1 : 2 * writes_of(c) + 1;
   endfunction

   // Word-level semantics: ascending copy/fill of w words with address wrap.
   task automatic apply_model(cmd_t c, int w);
      logic [15:0] v;
      exp_sum = '0;
      for (int i = 0; i < w; i++) begin
         v = c.fill ? c.data : exp_mem[(c.src + i) % WORDS];
         exp_mem[(c.dst + i) % WORDS] = v;
         exp_sum = exp_sum + v;
      end
   endtask

   task automatic drive_cmd(cmd_t c);
      cmd_fill  = c.fill;
      cmd_src   = 7'(c.src);
      cmd_dst   = 7'(c.dst);
      cmd_len   = 8'(c.len);
      cmd_data  = c.data;
      cmd_valid = 1'b1;
   endtask

   task automatic accept(cmd_t c);
      check("cmd_ready before accept", {31'd0, cmd_ready}, 32'd1);
      drive_cmd(c);
      abort = ($urandom_range(0, 3) == 0);   // abort while idle must be ignored
      wr0   = wr_count;
      acc0  = acc_count;
      exp_w = writes_of(c);
      exp_r = reads_of(c);
      apply_model(c, exp_w);
      step();
   endtask

   task automatic finish(cmd_t c, int exp_lat, int exp_cnt, bit exp_ab);
      int cyc  = 1;
      int wcnt = 0;
      int rcnt = 0;
      int nbad = 0;
      bit to   = 1'b0;
      check("cmd_ready while busy", {31'd0, cmd_ready}, 32'd0);
      if (c.len > 0) begin
         check("busy", {31'd0, busy}, 32'd1);
         check("first ram_cen", {31'd0, ram_cen}, 32'd0);
         check("first ram_wen", {30'd0, ram_wen}, c.fill ? 32'd0 : 32'd3);
         check("first ram_addr", {25'd0, ram_addr}, 32'((c.fill ? c.dst : c.src) % WORDS));
      end
      while (done !== 1'b1) begin
         if (cyc > 2 * c.len + 8) begin
            to = 1'b1;
            break;
         end
         abort = 1'b0;
         if (ram_cen == 1'b0) begin
            if (ram_wen == 2'b00) wcnt++; else rcnt++;
            if (c.akind == 1 && ram_wen == 2'b00 && wcnt == c.an) abort = 1'b1;
            if (c.akind == 2 && ram_wen == 2'b11 && rcnt == c.an) abort = 1'b1;
         end
         if (done_abort !== 1'b0) check("done_abort without done", {31'd0, done_abort}, 32'd0);
         step();
         cyc++;
      end
      abort = 1'b0;
      check("done timeout", {31'd0, to}, 32'd0);
      if (to) begin
         do_reset();
         return;
      end
      check("done latency", cyc, exp_lat);
      check("done_abort", {31'd0, done_abort}, {31'd0, exp_ab});
      check("xfer_cnt at done", {24'd0, xfer_cnt}, exp_cnt);
      check("write count", wr_count - wr0, exp_w);
      check("access count", acc_count - acc0, exp_w + exp_r);
`ifdef SOC_MSP430_RAM_DMA_CHECKSUM_EN
      check("checksum", {16'd0, checksum}, {16'd0, exp_sum});
`endif
      step();
      check("done one cycle", {31'd0, done}, 32'd0);
      check("cmd_ready after done", {31'd0, cmd_ready}, 32'd1);
      check("busy after done", {31'd0, busy}, 32'd0);
      check("xfer_cnt held", {24'd0, xfer_cnt}, exp_cnt);
      for (int i = 0; i < WORDS; i++) if (mem[i] !== exp_mem[i]) nbad++;
      check("ram contents", nbad, 0);
   endtask

   task automatic run(cmd_t c, int exp_lat, int exp_cnt, bit exp_ab);
      accept(c);
      cmd_valid = 1'b0;
      finish(c, exp_lat, exp_cnt, exp_ab);
   endtask

   initial begin
      vec_t vt[9];
      cmd_t c, c2;
      bit   saw_done;

      vt[0] = '{c: mk(0, 'h10, 'h20, 4, 16'h0000, 0, 0), exp_lat: 9, exp_cnt: 4, exp_ab: 0};
      vt[1] = '{c: mk(1, 'h00, 'h7E, 4, 16'hA5A5, 0, 0), exp_lat: 5, exp_cnt: 4, exp_ab: 0};
      vt[2] = '{c: mk(0, 'h05, 'h06, 0, 16'h0000, 0, 0), exp_lat: 1, exp_cnt: 0, exp_ab: 0};
      vt[3] = '{c: mk(0, 'h30, 'h40, 8, 16'h0000, 1, 2), exp_lat: 5, exp_cnt: 2, exp_ab: 1};
      vt[4] = '{c: mk(1, 'h00, 'h08, 3, 16'h5A5A, 1, 3), exp_lat: 4, exp_cnt: 3, exp_ab: 1};
      vt[5] = '{c: mk(0, 'h44, 'h70, 5, 16'h0000, 2, 2), exp_lat: 4, exp_cnt: 1, exp_ab: 1};
      vt[6] = '{c: mk(0, 'h50, 'h51, 4, 16'h0000, 0, 0), exp_lat: 9, exp_cnt: 4, exp_ab: 0};
      vt[7] = '{c: mk(0, 'h7F, 'h00, 1, 16'h0000, 0, 0), exp_lat: 3, exp_cnt: 1, exp_ab: 0};
      vt[8] = '{c: mk(1, 'h00, 'h00, 128, 16'h1234, 0, 0), exp_lat: 129, exp_cnt: 128, exp_ab: 0};

      // Reset values while rst_n is held low
      step();
      step();
      check("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {30'd0, done, done_abort}, 32'd0);
      check("reset xfer_cnt", {24'd0, xfer_cnt}, 32'd0);
      check("reset ram_cen/wen", {29'd0, ram_cen, ram_wen}, 32'd7);
      check("reset ram_addr/din", {9'd0, ram_addr, ram_din}, 32'd0);
      rst_n = 1'b1;
      step();

      rand_mem();
      preset('h10, 16'h1111);
      preset('h11, 16'h2222);
      preset('h12, 16'h3333);
      preset('h13, 16'h4444);

      for (int i = 0; i < 9; i++) begin
         run(vt[i].c, vt[i].exp_lat, vt[i].exp_cnt, vt[i].exp_ab);
         if (i == 0) begin
            check("copy dst 0x20", {16'd0, mem['h20]}, 32'h1111);
            check("copy dst 0x23", {16'd0, mem['h23]}, 32'h4444);
         end
         if (i == 1) begin
            check("fill wrap 0x7F", {16'd0, mem['h7F]}, 32'hA5A5);
            check("fill wrap 0x01", {16'd0, mem['h01]}, 32'hA5A5);
`ifdef SOC_MSP430_RAM_DMA_CHECKSUM_EN
            check("fill checksum", {16'd0, checksum}, 32'h9694);
`endif
         end
      end

      // Reset in the middle of a fill: three writes land, then everything returns to reset values
      rand_mem();
      c = mk(1, 0, 'h60, 10, 16'hBEEF, 0, 0);
      drive_cmd(c);
      wr0 = wr_count;
      step();
      cmd_valid = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("mid reset ram_cen", {31'd0, ram_cen}, 32'd1);
      check("mid reset ram_wen", {30'd0, ram_wen}, 32'd3);
      check("mid reset busy", {31'd0, busy}, 32'd0);
      check("mid reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("mid reset xfer_cnt", {24'd0, xfer_cnt}, 32'd0);
      check("mid reset partial writes", wr_count - wr0, 3);
      apply_model(c, 3);
      saw_done = done;
      for (int i = 0; i < 4; i++) begin
         step();
         saw_done = saw_done | done;
      end
      check("no done after reset", {31'd0, saw_done}, 32'd0);
      run(mk(0, 'h20, 'h30, 6, 16'h0000, 0, 0), 13, 6, 0);

      // cmd_valid held with new values during a copy, then accepted right after done
      c  = mk(0, 'h10, 'h60, 6, 16'h0000, 0, 0);
      c2 = mk(1, 'h00, 'h68, 3, 16'hC0DE, 0, 0);
      accept(c);
      drive_cmd(c2);
      finish(c, 13, 6, 0);
      accept(c2);
      cmd_valid = 1'b0;
      finish(c2, 4, 3, 0);

      // Randomized commands against the word-level model
      rand_mem();
      for (int n = 0; n < 40; n++) begin
         c = mk($urandom_range(0, 1), $urandom_range(0, 127), $urandom_range(0, 127),
                0, 16'($urandom), 0, 0);
         c.len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 128) : $urandom_range(0, 12);
         if (c.len > 0 && $urandom_range(0, 4) == 0) begin
            c.akind = (!c.fill && $urandom_range(0, 1) == 1) ? 2 : 1;
            c.an    = $urandom_range(1, c.len);
         end
         run(c, lat_of(c), writes_of(c), c.akind != 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
